sadd_result_deser: RTL and testbench

//   Downstream stage of the bit-serial adder. Collects the sum bit stream (LSB first) plus the final

---
 rtl/sadd_result_deser.sv | 119 +++++++++++
 tb/tb_sadd_result_deser.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sadd_result_deser.sv
// Result deserializer for the bit-serial adder: gathers LSB-first sum bits plus the final carry
// into a WIDTH+1 word, offers it on valid/ready, and flags protocol misuse with a sticky error.
module sadd_result_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_vld,
  input  logic             sum_bit,
  input  logic             carry_i,
  output logic [WIDTH:0]   res,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Handshake: res is transferred on any rising edge where res_vld & res_rdy are both 1;
  // while res_vld is 1 and res_rdy is 0, res is held stable and res_vld stays high.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   res_q, res_d;
  logic             res_vld_q, res_vld_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    res_vld_d = res_vld_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = COLLECT;
        end else if (bit_vld) begin
          err_d = 1'b1;
        end
      end
      COLLECT: begin
        // A start here aborts the partial word; any bit arriving with it is discarded too.
        if (start) begin
          shreg_d = '0;
          cnt_d   = '0;
        end else if (bit_vld) begin
          shreg_d = {sum_bit, shreg_q[WIDTH-1:1]};
          if (cnt_q == CW'(WIDTH - 1)) begin
            res_d     = {carry_i, sum_bit, shreg_q[WIDTH-1:1]};
            res_vld_d = 1'b1;
            cnt_d     = '0;
            state_d   = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (bit_vld) err_d = 1'b1;
        if (res_rdy) begin
          res_vld_d = 1'b0;
          if (start) begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = COLLECT;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        res_vld_d = 1'b0;
      end
    endcase
    busy_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign res     = res_q;
  assign res_vld = res_vld_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sadd_result_deser.sv
// Directed bench for sadd_result_deser (WIDTH=4): a vector table for the main word flows, plus
// hand-written sequences for asynchronous reset and sticky-error behaviour.
module tb_sadd_result_deser;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, bit_vld, sum_bit, carry_i, res_rdy;
  logic [WIDTH:0]   res;
  logic             res_vld, busy, err;

  int checks   = 0;
  int failures = 0;

  sadd_result_deser #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bit_vld (bit_vld),
    .sum_bit (sum_bit),
    .carry_i (carry_i),
    .res     (res),
    .res_vld (res_vld),
    .res_rdy (res_rdy),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           start;
    logic           bit_vld;
    logic           sum_bit;
    logic           carry_i;
    logic           res_rdy;
    logic [WIDTH:0] res;
    logic           vld;
    logic           busy;
    logic           err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, v, b, c, r, input logic [WIDTH:0] e_res,
                              input logic e_vld, e_busy, e_err);
    vec_t t;
    t = '{s, v, b, c, r, e_res, e_vld, e_busy, e_err};
    vecs.push_back(t);
  endfunction

  task automatic drive(input logic s, v, b, c, r);
    start   = s;
    bit_vld = v;
    sum_bit = b;
    carry_i = c;
    res_rdy = r;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [WIDTH:0] e_res,
                         input logic e_vld, e_busy, e_err);
    chk({tag, ".res"},     32'(res),     32'(e_res));
    chk({tag, ".res_vld"}, 32'(res_vld), 32'(e_vld));
    chk({tag, ".busy"},    32'(busy),    32'(e_busy));
    chk({tag, ".err"},     32'(err),     32'(e_err));
  endtask

  initial begin
    //   s  v  b  c  r   res        vld busy err
    // Basic add 1,0,0,1; start wins over a simultaneous bit in IDLE without raising err.
    add(1, 1, 1, 0, 0, 5'b00000, 0, 1, 0);
    add(0, 1, 1, 0, 0, 5'b00000, 0, 1, 0);
    add(0, 1, 0, 0, 0, 5'b00000, 0, 1, 0);
    add(0, 1, 0, 0, 0, 5'b00000, 0, 1, 0);
    add(0, 1, 1, 0, 1, 5'b01001, 1, 0, 0);
    add(0, 0, 0, 0, 1, 5'b01001, 0, 0, 0);
    add(0, 0, 0, 0, 1, 5'b01001, 0, 0, 0);
    // Final carry: 0,0,0,0 with carry 1.
    add(1, 0, 0, 0, 0, 5'b01001, 0, 1, 0);
    add(0, 1, 0, 0, 0, 5'b01001, 0, 1, 0);
    add(0, 1, 0, 0, 0, 5'b01001, 0, 1, 0);
    add(0, 1, 0, 0, 0, 5'b01001, 0, 1, 0);
    add(0, 1, 0, 1, 1, 5'b10000, 1, 0, 0);
    add(0, 0, 0, 0, 1, 5'b10000, 0, 0, 0);
    // Backpressure: 1,1,0,0 held for 5 cycles; start in HOLD is an error.
    add(1, 0, 0, 0, 0, 5'b10000, 0, 1, 0);
    add(0, 1, 1, 0, 0, 5'b10000, 0, 1, 0);
    add(0, 1, 1, 0, 0, 5'b10000, 0, 1, 0);
    add(0, 1, 0, 0, 0, 5'b10000, 0, 1, 0);
    add(0, 1, 0, 0, 0, 5'b00011, 1, 0, 0);
    add(0, 0, 0, 0, 0, 5'b00011, 1, 0, 0);
    add(0, 0, 0, 0, 0, 5'b00011, 1, 0, 0);
    add(1, 0, 0, 0, 0, 5'b00011, 1, 0, 1);
    add(0, 0, 0, 0, 0, 5'b00011, 1, 0, 1);
    add(0, 0, 0, 0, 0, 5'b00011, 1, 0, 1);
    add(0, 0, 0, 0, 1, 5'b00011, 0, 0, 1);
    // Back-to-back: word 0,1,0,0 then accept+start, then 1,1,1,1 carry 1.
    add(1, 0, 0, 0, 0, 5'b00011, 0, 1, 1);
    add(0, 1, 0, 0, 0, 5'b00011, 0, 1, 1);
    add(0, 1, 1, 0, 0, 5'b00011, 0, 1, 1);
    add(0, 1, 0, 0, 0, 5'b00011, 0, 1, 1);
    add(0, 1, 0, 0, 0, 5'b00010, 1, 0, 1);
    add(1, 0, 0, 0, 1, 5'b00010, 0, 1, 1);
    add(0, 1, 1, 0, 0, 5'b00010, 0, 1, 1);
    add(0, 1, 1, 0, 0, 5'b00010, 0, 1, 1);
    add(0, 1, 1, 0, 0, 5'b00010, 0, 1, 1);
    add(0, 1, 1, 1, 0, 5'b11111, 1, 0, 1);
    add(0, 0, 0, 0, 1, 5'b11111, 0, 0, 1);
    // Abort after 2 bits (the aborting start carries a bit that must be dropped), then 0,1,0,1.
    add(1, 0, 0, 0, 0, 5'b11111, 0, 1, 1);
    add(0, 1, 1, 0, 0, 5'b11111, 0, 1, 1);
    add(0, 1, 1, 0, 0, 5'b11111, 0, 1, 1);
    add(1, 1, 1, 0, 0, 5'b11111, 0, 1, 1);
    add(0, 1, 0, 0, 0, 5'b11111, 0, 1, 1);
    add(0, 1, 1, 0, 0, 5'b11111, 0, 1, 1);
    add(0, 1, 0, 0, 0, 5'b11111, 0, 1, 1);
    add(0, 1, 1, 0, 0, 5'b01010, 1, 0, 1);
    add(0, 0, 0, 0, 1, 5'b01010, 0, 0, 1);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #12;
    chk_all("reset", 5'b00000, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].bit_vld, vecs[i].sum_bit, vecs[i].carry_i, vecs[i].res_rdy);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].res, vecs[i].vld, vecs[i].busy, vecs[i].err);
    end

    // Reset after 2 bits of a word: everything clears without waiting for a clock edge.
    drive(1, 0, 0, 0, 0); step();
    drive(0, 1, 1, 0, 0); step();
    drive(0, 1, 1, 0, 0); step();
    chk("midword.busy", 32'(busy), 32'd1);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk_all("rst_midword", 5'b00000, 0, 0, 0);
    #2 rst = 1'b0;

    // Stray bit in IDLE sets err, which survives a later good word.
    drive(0, 1, 1, 0, 0); step();
    chk_all("idle_bit", 5'b00000, 0, 0, 1);
    drive(1, 0, 0, 0, 0); step();
    drive(0, 1, 1, 0, 0); step();
    drive(0, 1, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0); step();
    drive(0, 1, 1, 0, 0); step();
    chk_all("sticky_word", 5'b01001, 1, 0, 1);
    // A bit offered while holding is dropped: result unchanged, still waiting.
    drive(0, 1, 0, 1, 0); step();
    chk_all("hold_bit", 5'b01001, 1, 0, 1);
    // Reset while holding: res_vld falls immediately and err finally clears.
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk_all("rst_hold", 5'b00000, 0, 0, 0);
    #2 rst = 1'b0;
    step();
    chk_all("after_rst", 5'b00000, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
